io_responder: RTL and testbench

Memory-mapped I/O responder on the CPU memory bus, serving the upper half of the 9-bit address space (`mem_addr[8]=1`) that the on-chip RAM ignores. It decodes `M_READ`/`M_WRITE` commands and holds an LED output register and a two-flop-synchronised switch input. An optional prescaled interval timer provides a sticky tick flag and an interrupt line. It sits beside the RAM at top level and shares the tri-stated `mem_data` read bus.

---
 rtl/io_responder_pkg.sv | 25 ++
 rtl/io_responder_timer.sv | 74 +++++++
 rtl/io_responder.sv | 125 ++++++++++++
 tb/tb_io_responder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/io_responder_pkg.sv
`default_nettype none
// ============================================================================
// Package  : io_pkg
// Purpose  : Shared bus command encoding and register addresses for the
//            memory-mapped I/O responder.
// Contents : mem_cmd_t  - CPU memory bus command (code 11 behaves as NOP)
//            IO_*       - full 9-bit register addresses in the upper half
// Revision : 1.0 - initial release
// ============================================================================
package io_pkg;

  typedef enum logic [1:0] {
    M_NOP   = 2'b00,
    M_WRITE = 2'b01,
    M_READ  = 2'b10
  } mem_cmd_t;

  localparam logic [8:0] IO_LED    = 9'h100;
  localparam logic [8:0] IO_SW     = 9'h140;
  localparam logic [8:0] IO_COUNT  = 9'h141;
  localparam logic [8:0] IO_STATUS = 9'h142;
  localparam logic [8:0] IO_PERIOD = 9'h143;

endpackage : io_pkg
`default_nettype wire

// File: rtl/io_responder_timer.sv
`default_nettype none
// ============================================================================
// Module   : io_timer
// Purpose  : Prescaled interval timer with a sticky, write-1-to-clear tick flag.
// Ports    : clk        in   bus clock
//            reset_n    in   asynchronous active-low reset
//            period_we  in   load PERIOD; also restarts COUNT and prescaler
//            period_d   in   new PERIOD value
//            clr        in   clear tick flag (loses against a same-edge tick)
//            count      out  current COUNT
//            period     out  current PERIOD
//            flag       out  sticky tick flag
// Params   : PRESCALE   clk cycles per COUNT advance (>= 1)
// Revision : 1.0 - initial release
// ============================================================================
module io_timer #(
  parameter int PRESCALE = 50000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        period_we,
  input  logic [15:0] period_d,
  input  logic        clr,
  output logic [15:0] count,
  output logic [15:0] period,
  output logic        flag
);

  localparam int              c_pw   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [c_pw-1:0] c_last = c_pw'(PRESCALE - 1);

  logic [c_pw-1:0] r_presc;
  logic [15:0]     r_count;
  logic [15:0]     r_period;
  logic            r_flag;

  logic            w_adv;
  logic            w_wrap;

  assign w_adv  = (r_presc == c_last);
  // PERIOD==0 means free-running: never matches, so COUNT wraps 0xFFFF->0.
  assign w_wrap = w_adv && (r_period != 16'd0) && (r_count == r_period);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc  <= '0;
      r_count  <= '0;
      r_period <= '0;
      r_flag   <= 1'b0;
    end else if (period_we) begin
      // A PERIOD load restarts the interval; any advance due this edge is dropped.
      r_period <= period_d;
      r_count  <= '0;
      r_presc  <= '0;
    end else begin
      r_presc <= w_adv ? '0 : r_presc + 1'b1;
      if (w_adv) begin
        r_count <= w_wrap ? 16'd0 : r_count + 16'd1;
      end
      // Tick beats a same-edge clear so no event is ever lost.
      if (w_wrap) begin
        r_flag <= 1'b1;
      end else if (clr) begin
        r_flag <= 1'b0;
      end
    end
  end

  assign count  = r_count;
  assign period = r_period;
  assign flag   = r_flag;

endmodule : io_timer
`default_nettype wire

// File: rtl/io_responder.sv
`default_nettype none
// ============================================================================
// Module   : io_responder
// Purpose  : Memory-mapped I/O responder for the upper half of the 9-bit CPU
//            address space (mem_addr[8]=1). LED register, synchronised switch
//            input and, optionally, an interval timer with interrupt.
// Ports    : clk       in   bus clock
//            reset_n   in   asynchronous active-low reset
//            mem_cmd   in   bus command (io_pkg::mem_cmd_t encoding)
//            mem_addr  in   bus address
//            din       in   CPU write data
//            mem_data  out  tri-stated read data, driven only on a read hit
//            sw        in   raw asynchronous switches
//            led       out  LED register
//            irq       out  level interrupt, equals the tick flag
// Params   : PRESCALE  clk cycles per timer count (timer build only)
// Macro    : IO_TIMER_EN - build the io_timer; otherwise 0x141..0x143 read 0
// Revision : 1.0 - initial release
// ============================================================================
module io_responder
  import io_pkg::*;
#(
  parameter int PRESCALE = 50000
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [1:0]     mem_cmd,
  input  logic [8:0]     mem_addr,
  input  logic [15:0]    din,
  output tri logic [15:0] mem_data,
  input  logic [7:0]     sw,
  output logic [7:0]     led,
  output logic           irq
);

  if (PRESCALE < 1) begin : g_prescale_check
    $error("io_responder: PRESCALE must be >= 1");
  end

  logic        w_hit;
  logic        w_rd;
  logic        w_wr;
  logic [15:0] w_rd_val;
  logic [15:0] w_count;
  logic [15:0] w_period;
  logic        w_flag;

  logic [7:0]  r_led;
  logic [7:0]  r_sw_meta;
  logic [7:0]  r_sw_sync;
  logic [15:0] r_rdata;

  assign w_hit = mem_addr[8];
  assign w_rd  = w_hit && (mem_cmd == M_READ);
  assign w_wr  = w_hit && (mem_cmd == M_WRITE);

  // Two-flop synchroniser for the asynchronous switches.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sw_meta <= sw;
      r_sw_sync <= r_sw_meta;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_led <= '0;
    end else if (w_wr && (mem_addr == IO_LED)) begin
      r_led <= din[7:0];
    end
  end

`ifdef IO_TIMER_EN
  io_timer #(
    .PRESCALE (PRESCALE)
  ) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .period_we (w_wr && (mem_addr == IO_PERIOD)),
    .period_d  (din),
    .clr       (w_wr && (mem_addr == IO_STATUS) && din[0]),
    .count     (w_count),
    .period    (w_period),
    .flag      (w_flag)
  );
`else
  logic w_unused_din;

  assign w_count      = '0;
  assign w_period     = '0;
  assign w_flag       = 1'b0;
  assign w_unused_din = ^din[15:8];
`endif

  always_comb begin
    w_rd_val = 16'h0000;
    case (mem_addr)
      IO_LED:    w_rd_val = {8'h00, r_led};
      IO_SW:     w_rd_val = {8'h00, r_sw_sync};
      IO_COUNT:  w_rd_val = w_count;
      IO_STATUS: w_rd_val = {15'h0000, w_flag};
      IO_PERIOD: w_rd_val = w_period;
      default:   w_rd_val = 16'h0000;
    endcase
  end

  // One-edge read latency, matching the RAM beside this block.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata <= '0;
    end else if (w_rd) begin
      r_rdata <= w_rd_val;
    end
  end

  // Released while in reset so an aborted read never drives the shared bus.
  assign mem_data = (reset_n && w_rd) ? r_rdata : 16'hzzzz;
  assign led      = r_led;
  assign irq      = w_flag;

endmodule : io_responder
`default_nettype wire

// File: tb/tb_io_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_responder
// Purpose  : Self-checking bench for io_responder. A behavioural model tracks
//            registers, switch pipeline and the timer by elapsed-edge
//            arithmetic; every cycle the bus, led and irq are compared.
//            The shared bus carries a pull-up, so a released bus reads 0xFFFF.
// Macro    : IO_TIMER_EN - selects timer or timer-less expectations
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_responder;

  localparam int c_prescale = 4;
`ifdef IO_TIMER_EN
  localparam bit c_timer = 1'b1;
`else
  localparam bit c_timer = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  mem_cmd = 2'b00;
  logic [8:0]  mem_addr = '0;
  logic [15:0] din = '0;
  logic [7:0]  sw = '0;
  logic [7:0]  led;
  logic        irq;
  wire  [15:0] mem_bus;

  pullup (mem_bus);

  io_responder #(.PRESCALE(c_prescale)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .mem_cmd  (mem_cmd),
    .mem_addr (mem_addr),
    .din      (din),
    .mem_data (mem_bus),
    .sw       (sw),
    .led      (led),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_edges;   // edges since reset or last PERIOD load
  logic [15:0] m_period;
  bit          m_flag;
  logic [7:0]  m_led, m_s1, m_s2;
  logic [15:0] m_rdata;

  task automatic model_reset();
    m_edges = 0; m_period = '0; m_flag = 0;
    m_led = '0; m_s1 = '0; m_s2 = '0; m_rdata = '0;
  endtask

  function automatic logic [15:0] m_count();
    int k = m_edges / c_prescale;
    if (m_period != 0) return 16'(k % (int'(m_period) + 1));
    return 16'(k % 65536);
  endfunction

  function automatic bit m_event_next();
    int e = m_edges + 1;
    if (m_period == 0 || (e % c_prescale) != 0) return 0;
    return ((e / c_prescale) % (int'(m_period) + 1)) == 0;
  endfunction

  function automatic logic [15:0] m_reg(input logic [8:0] a);
    case (a)
      9'h100:  return {8'h00, m_led};
      9'h140:  return {8'h00, m_s2};
      9'h141:  return c_timer ? m_count() : 16'h0;
      9'h142:  return c_timer ? {15'h0, m_flag} : 16'h0;
      9'h143:  return c_timer ? m_period : 16'h0;
      default: return 16'h0;
    endcase
  endfunction

  task automatic model_edge();
    bit ev;
    if (mem_cmd == 2'b10 && mem_addr[8]) m_rdata = m_reg(mem_addr);
    ev = c_timer && m_event_next();
    if (c_timer && mem_cmd == 2'b01 && mem_addr == 9'h143) begin
      m_period = din;
      m_edges  = 0;
    end else begin
      m_edges++;
      if (ev) m_flag = 1;
      else if (mem_cmd == 2'b01 && mem_addr == 9'h142 && din[0]) m_flag = 0;
    end
    if (mem_cmd == 2'b01 && mem_addr == 9'h100) m_led = din[7:0];
    m_s2 = m_s1;
    m_s1 = sw;
  endtask

  task automatic check_outputs();
    logic [15:0] exp_bus;
    exp_bus = (reset_n && mem_cmd == 2'b10 && mem_addr[8]) ? m_rdata : 16'hFFFF;
    check_val("bus", mem_bus, exp_bus);
    check_val("led", {8'h00, led}, {8'h00, m_led});
    check_val("irq", {15'h0, irq}, {15'h0, c_timer && m_flag});
  endtask

  task automatic cycle();
    @(posedge clk);
    if (reset_n) model_edge();
    #1;
    check_outputs();
  endtask

  task automatic wr(input logic [8:0] a, input logic [15:0] d);
    mem_cmd = 2'b01; mem_addr = a; din = d;
    cycle();
    mem_cmd = 2'b00;
  endtask

  task automatic rd(input logic [8:0] a);
    mem_cmd = 2'b10; mem_addr = a;
    cycle();
    cycle();
  endtask

  function automatic logic [8:0] rand_addr();
    case ($urandom_range(0, 7))
      0: return 9'h100;
      1: return 9'h140;
      2: return 9'h141;
      3: return 9'h142;
      4: return 9'h143;
      5: return {1'b1, 8'($urandom)};
      6: return {1'b0, 8'($urandom)};
      default: return 9'h1FF;
    endcase
  endfunction

  initial begin
    model_reset();
    // Reset state
    for (int i = 0; i < 3; i++) cycle();
    reset_n = 1'b1;
    cycle();
    rd(9'h100); check_val("rst_led_rd", mem_bus, 16'h0000);
    rd(9'h142); check_val("rst_status_rd", mem_bus, 16'h0000);
    rd(9'h143); check_val("rst_period_rd", mem_bus, 16'h0000);
    mem_cmd = 2'b00; mem_addr = 9'h100; cycle();
    check_val("nop_release", mem_bus, 16'hFFFF);
    rd(9'h000); check_val("low_release0", mem_bus, 16'hFFFF);
    rd(9'h0FF); check_val("low_release1", mem_bus, 16'hFFFF);

    // LED write/read, unmapped read
    wr(9'h100, 16'h00A5);
    check_val("led_a5", {8'h00, led}, 16'h00A5);
    rd(9'h100); check_val("led_rd", mem_bus, 16'h00A5);
    rd(9'h1FF); check_val("unmapped_rd", mem_bus, 16'h0000);

    // Switch synchronisation
    sw = 8'h3C;
    mem_cmd = 2'b00;
    for (int i = 0; i < 3; i++) cycle();
    rd(9'h140); check_val("sw_3c", mem_bus, 16'h003C);
    sw = 8'h81;
    cycle(); check_val("sw_lag1", mem_bus, 16'h003C);
    cycle(); check_val("sw_lag2", mem_bus, 16'h003C);
    cycle(); check_val("sw_new", mem_bus, 16'h0081);

`ifdef IO_TIMER_EN
    // Timer: PERIOD=3 gives COUNT 0,1,2,3,0 with 4 cycles per count
    wr(9'h143, 16'd3);
    mem_cmd = 2'b10; mem_addr = 9'h141;
    for (int i = 0; i < 20; i++) cycle();
    check_val("irq_set", {15'h0, irq}, 16'h0001);
    wr(9'h142, 16'h0001);
    check_val("irq_w1c", {15'h0, irq}, 16'h0000);
    begin
      int guard = 0;
      while (!m_event_next() && guard < 200) begin cycle(); guard++; end
      check_val("tick_found", 16'(guard < 200), 16'h0001);
    end
    wr(9'h142, 16'h0001);
    check_val("set_wins", {15'h0, irq}, 16'h0001);
    mem_cmd = 2'b10; mem_addr = 9'h141;
    for (int i = 0; i < 6; i++) cycle();
    wr(9'h143, 16'd5);
    rd(9'h141); check_val("count_restart", mem_bus, 16'h0000);
`else
    wr(9'h141, 16'h1234); wr(9'h142, 16'h0001); wr(9'h143, 16'h0007);
    rd(9'h141); check_val("nt_count", mem_bus, 16'h0000);
    rd(9'h142); check_val("nt_status", mem_bus, 16'h0000);
    rd(9'h143); check_val("nt_period", mem_bus, 16'h0000);
`endif

    // Randomised traffic
    for (int t = 0; t < 1000; t++) begin
      if ($urandom_range(0, 7) == 0) sw = 8'($urandom);
      mem_addr = rand_addr();
      case ($urandom_range(0, 3))
        0: begin mem_cmd = 2'b00; cycle(); end
        1: begin mem_cmd = 2'b11; cycle(); end
        2: begin
          if (mem_addr == 9'h143)
            din = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 16'hFFFE))
                                              : 16'($urandom_range(0, 5));
          else
            din = 16'($urandom);
          mem_cmd = 2'b01; cycle();
        end
        default: begin mem_cmd = 2'b10; cycle(); cycle(); end
      endcase
    end

    // Reset asserted mid-read
    wr(9'h100, 16'h005A);
    mem_cmd = 2'b10; mem_addr = 9'h100;
    cycle();
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_val("rst_mid_bus", mem_bus, 16'hFFFF);
    check_val("rst_mid_led", {8'h00, led}, 16'h0000);
    check_val("rst_mid_irq", {15'h0, irq}, 16'h0000);
    cycle(); cycle();
    reset_n = 1'b1;
    rd(9'h100); check_val("post_rst_led", mem_bus, 16'h0000);
    rd(9'h143); check_val("post_rst_period", mem_bus, 16'h0000);
    rd(9'h142); check_val("post_rst_status", mem_bus, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_io_responder
`default_nettype wire
